product_bcd_converter: RTL and testbench
========================================

// Module: product_bcd_converter
// PURPOSE
//   Downstream stage of the sequential multiplier. Accepts a finished binary product
//   and converts it to packed BCD using sequential shift-add-3 (double dabble),
//   one bit per clock. Its output drives the display/readout path.
//   A valid/ready handshake sits on both sides, so it can stall the multiplier's consumer.
// PARAMETERS
//   WIDTH   8   binary input width (multiplier product width)
//   DIGITS  3   BCD output digits; must satisfy 10**DIGITS > 2**WIDTH - 1
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous, active-low reset
//   in_valid   in   1            product is valid to accept
//   in_ready   out  1            converter can accept (IDLE only)
//   product    in   WIDTH        binary value from multiplier
//   out_valid  out  1            bcd holds a completed conversion
//   out_ready  in   1            consumer takes the result
//   bcd        out  4*DIGITS     packed BCD, digit 0 in [3:0]
//   busy       out  1            high in SHIFT or DONE
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, bcd=0, out_valid=0, busy=0, bit count=0,
//     shift reg=0. in_ready=1 once rst deasserts.
//   FSM states: IDLE, SHIFT, DONE.
//   IDLE: in_ready=1. On an edge with in_valid=1:
//     - latch product into the binary shift reg
//     - clear the BCD accumulator to 0
//     - load count=WIDTH; go to SHIFT
//     in_valid=0: stay in IDLE; bcd holds the last result.
//   SHIFT: in_ready=0, in_valid ignored. Each edge does two steps:
//     - every 4-bit digit >=5 gets +3
//     - {bcd_acc, bin} shifts left by 1 (bin MSB enters digit-0 LSB)
//     - count decrements
//     The edge that performs shift number WIDTH moves to DONE.
//   DONE: out_valid=1; bcd holds the final value, stable while out_ready=0.
//     An edge with out_ready=1 moves to IDLE and clears out_valid.
//   Latency: acceptance edge E0 -> out_valid high after edge E_WIDTH
//     (8 cycles at default).
//   Throughput: one result per WIDTH+2 cycles minimum. in_ready is low in DONE,
//     so in_valid and out_ready together in DONE give one bubble cycle before
//     the next accept.
//   Arithmetic:
//     - add-3 is applied per digit before the shift, never after the final shift
//     - no digit ever exceeds 9
//     - digit overflow cannot occur given the DIGITS constraint
//   bcd is the accumulator register; it updates only in SHIFT, or clears at acceptance.
//     Intermediate values are visible during SHIFT; consumers qualify with out_valid.
//   Reset mid-SHIFT or mid-DONE: aborts immediately, all outputs return to reset values.
//   product sampled only at the acceptance edge; later changes have no effect.
// TESTING
//   1 product=8'b00010010 (18), in_valid pulse, out_ready=1
//     -> out_valid after 8 edges, bcd=12'h018, back to IDLE next edge
//   2 product=8'hFF -> bcd=12'h255; product=8'h00 -> bcd=12'h000;
//     product=8'd99 -> bcd=12'h099
//   3 out_ready=0 for 5 cycles in DONE
//     -> out_valid and bcd=12'h018 held stable, in_ready=0 throughout
//   4 product changed and in_valid=1 during SHIFT
//     -> ignored, result matches originally latched value
//   5 rst=0 asserted mid-SHIFT (after 4 shifts, asynchronously between edges)
//     -> bcd=0, out_valid=0, busy=0 immediately
//     -> after release, a fresh 8'd200 converts to 12'h200
//   6 back-to-back: in_valid held high with 18 then 255, out_ready=1
//     -> two results 12'h018, 12'h255, second accepted exactly one cycle after
//        first out_valid drop

Source files
------------

// File: rtl/product_bcd_converter_if.sv
// rtl/product_bcd_converter_if.sv - handshake bundle between multiplier product and BCD readout
interface product_bcd_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      product;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;

  modport master (
    output in_valid, product, out_ready,
    input  in_ready, out_valid, bcd, busy
  );

  modport slave (
    input  in_valid, product, out_ready,
    output in_ready, out_valid, bcd, busy
  );
endinterface

// File: rtl/product_bcd_converter.sv
// rtl/product_bcd_converter.sv - sequential double-dabble binary to packed BCD converter
module product_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  product_bcd_converter_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Add 3 to every digit of 5 or more so the following shift carries correctly into the next digit
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state: accept in IDLE, one correct-and-shift per cycle in SHIFT, hold result in DONE
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          bin_d   = bus.product;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.bcd       = bcd_q;
endmodule

// File: tb/tb_product_bcd_converter.sv
// tb/tb_product_bcd_converter.sv - self-checking bench for product_bcd_converter
module tb_product_bcd_converter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [7:0]  product;
    logic [11:0] bcd;
  } vec_t;
  vec_t vecs[10];

  product_bcd_converter_if #(.WIDTH(8), .DIGITS(3)) bus ();

  product_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  // Scoreboard: each completed handshake pops the oldest expected result
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_unexpected actual=%0h expected=none", bus.bcd);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if (bus.bcd !== e) begin
          failures++;
          $display("FAIL scoreboard_bcd actual=%0h expected=%0h", bus.bcd, e);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL wait_ready actual=timeout expected=in_ready");
    end
  endtask

  task automatic send(input logic [7:0] p, input logic [11:0] e);
    wait_ready();
    bus.product  = p;
    bus.in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d_pending expected=0", exp_q.size());
    end
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      failures++;
      $display("FAIL wait_out_valid actual=timeout expected=out_valid");
    end
  endtask

  initial begin
    int lat;
    vecs[0] = '{8'd18,  12'h018};
    vecs[1] = '{8'hFF,  12'h255};
    vecs[2] = '{8'h00,  12'h000};
    vecs[3] = '{8'd99,  12'h099};
    vecs[4] = '{8'd200, 12'h200};
    vecs[5] = '{8'd1,   12'h001};
    vecs[6] = '{8'd9,   12'h009};
    vecs[7] = '{8'd10,  12'h010};
    vecs[8] = '{8'd128, 12'h128};
    vecs[9] = '{8'd59,  12'h059};

    bus.in_valid  = 1'b0;
    bus.product   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_bcd", 32'(bus.bcd), 32'h0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'h1);

    // Latency: out_valid first seen after the eighth edge following acceptance
    bus.product  = 8'd18;
    bus.in_valid = 1'b1;
    exp_q.push_back(12'h018);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid && lat == 0) lat = k;
      if (k == 1) chk("shift_in_ready", 32'(bus.in_ready), 32'h0);
    end
    chk("latency", 32'(lat), 32'd8);
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_done_out_valid", 32'(bus.out_valid), 32'h0);
    chk("idle_after_done_in_ready", 32'(bus.in_ready), 32'h1);

    // Table-driven conversions plus a few random values against an arithmetic model
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].product, vecs[i].bcd);
      drain();
    end
    for (int i = 0; i < 4; i++) begin
      int v;
      v = int'($urandom_range(0, 255));
      send(8'(v), to_bcd(v));
      drain();
    end

    // Consumer stall in DONE
    bus.out_ready = 1'b0;
    send(8'd18, 12'h018);
    wait_out_valid();
    for (int k = 0; k < 5; k++) begin
      chk("stall_out_valid", 32'(bus.out_valid), 32'h1);
      chk("stall_bcd", 32'(bus.bcd), 32'h018);
      chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();

    // Input changes during SHIFT are ignored
    send(8'd99, 12'h099);
    repeat (2) @(posedge clk);
    #1;
    bus.product  = 8'hFF;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    drain();

    // Asynchronous reset mid-SHIFT
    wait_ready();
    bus.product  = 8'hFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_bcd", 32'(bus.bcd), 32'h0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    send(8'd200, 12'h200);
    drain();

    // Back-to-back with in_valid held high
    wait_ready();
    exp_q.push_back(12'h018);
    exp_q.push_back(12'h255);
    bus.product  = 8'd18;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.product = 8'hFF;
    wait_out_valid();
    @(posedge clk);
    @(negedge clk);
    chk("b2b_drop_out_valid", 32'(bus.out_valid), 32'h0);
    chk("b2b_drop_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("b2b_second_accept_busy", 32'(bus.busy), 32'h1);
    chk("b2b_second_accept_in_ready", 32'(bus.in_ready), 32'h0);
    bus.in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
